// File: rtl/shift_sequencer.sv
// shift_sequencer: splits a 0..31 shift into passes of at most STEP_MAX bits through an external shifter.
//   Ports:
//     clk        - system clock, all state changes on the rising edge
//     reset_n    - asynchronous active-low reset
//     start      - request pulse, sampled only in IDLE
//     din        - operand captured on an accepted start
//     total_amt  - total shift amount, captured on an accepted start
//     dir        - 0 = left, 1 = right, captured on an accepted start
//     sh_a       - operand to the external combinational shifter
//     sh_amt     - per-pass amount to the shifter (0 outside SHIFT)
//     sh_choice  - direction to the shifter
//     sh_y       - shifter result
//     busy       - high in SHIFT and DONE
//     done       - one-cycle completion pulse
//     dout       - final result, held until the next completion
//   Build option: define SHIFT_SEQ_MOD8_EN to use total_amt mod 8 (for rotate-type shifters).
module shift_sequencer #(
   parameter int STEP_MAX = 7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] din,
   input  logic [4:0] total_amt,
   input  logic       dir,
   output logic [7:0] sh_a,
   output logic [2:0] sh_amt,
   output logic       sh_choice,
   input  logic [7:0] sh_y,
   output logic       busy,
   output logic       done,
   output logic [7:0] dout
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [2:0] STEP = 3'(STEP_MAX);
   state_t     state, state_nxt;
   logic [7:0] acc, acc_nxt;
   logic [4:0] rem, rem_nxt, eff_amt;
   logic       dir_r, dir_nxt;
`ifdef SHIFT_SEQ_MOD8_EN
   assign eff_amt = {2'b00, total_amt[2:0]};
`else
   assign eff_amt = total_amt;
`endif
   assign sh_amt    = (state == SHIFT) ? ((rem > {2'b00, STEP}) ? STEP : rem[2:0]) : 3'd0;
   assign sh_a      = acc;
   assign sh_choice = dir_r;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      rem_nxt   = rem;
      dir_nxt   = dir_r;
      case (state)
         IDLE: if (start) begin
            acc_nxt   = din;
            rem_nxt   = eff_amt;
            dir_nxt   = dir;
            state_nxt = (eff_amt != 5'd0) ? SHIFT : DONE;
         end
         SHIFT: begin
            acc_nxt   = sh_y;
            rem_nxt   = rem - {2'b00, sh_amt};
            state_nxt = (rem_nxt == 5'd0) ? DONE : SHIFT;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // dout takes the value acc will hold on DONE entry, so it is valid alongside done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         acc   <= 8'd0;
         rem   <= 5'd0;
         dir_r <= 1'b0;
         dout  <= 8'd0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         rem   <= rem_nxt;
         dir_r <= dir_nxt;
         if (state_nxt == DONE) dout <= acc_nxt;
      end
   end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter STEP_MAX, default 7, maximum shift amount applied per pass (legal 1..7).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port din  input  8  operand captured on accepted start.
REQ-006 SHALL have port total_amt  input  5  total shift amount 0..31, captured on accepted start.
REQ-007 SHALL have port dir  input  1  0 = left, 1 = right, captured on accepted start.
REQ-008 SHALL have port sh_a  output  8  operand to the downstream combinational shifter.
REQ-009 SHALL have port sh_amt  output  3  per-pass amount to the shifter.
REQ-010 SHALL have port sh_choice  output  1  direction to the shifter, equal to the captured dir.
REQ-011 SHALL have port sh_y  input  8  shifter result, treated as opaque combinational data.
REQ-012 SHALL have port busy  output  1  high in SHIFT and DONE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port dout  output  8  final result, held until the next completion.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE, with registers acc[7:0], rem[4:0] and dir_r.
REQ-016 SHALL, in IDLE with start=1, load acc=din, rem=total_amt (or its effective value per REQ-027) and dir_r=dir; next state SHIFT if rem≠0, else DONE.
REQ-017 SHALL, in SHIFT, drive sh_a=acc, sh_amt=min(rem,STEP_MAX) and sh_choice=dir_r.
REQ-018 SHALL, on each SHIFT edge, update acc<=sh_y and rem<=rem-sh_amt; go to DONE when the new rem=0, else stay in SHIFT.
REQ-019 SHALL give a latency from the accepted start edge to done high of ceil(rem/STEP_MAX)+1 cycles (1 cycle when rem=0).
REQ-020 SHALL, in DONE, assert done for exactly one cycle, load dout<=acc on DONE entry, and return to IDLE.
REQ-021 SHALL drive sh_amt=0 in IDLE and DONE, with sh_a=acc and sh_choice=dir_r.
REQ-022 SHALL ignore start while busy=1; no recapture occurs and no queueing takes place.
REQ-023 SHALL accept a start in the IDLE cycle immediately after DONE (back-to-back operation).

Reset
REQ-024 SHALL, on reset_n low at any time including mid-SHIFT, immediately force state=IDLE, acc=0, rem=0, dir_r=0, dout=0, done=0, busy=0 and sh_amt=0.
REQ-025 SHALL resume normal operation on the first rising clk edge after reset_n deasserts; any in-flight operation is discarded.

Configuration
REQ-026 SHALL honour macro SHIFT_SEQ_MOD8_EN.
REQ-027 SHALL, with SHIFT_SEQ_MOD8_EN defined, use effective amount total_amt[2:0] (mod 8) for rotate-type shifters; without it, SHALL use the full 5-bit total_amt.

Verification (bench models sh_y as a logical shift: left a<<amt, right a>>amt, zero fill)
REQ-028 SHALL cover: din=0x81, total_amt=3, dir=0 -> one SHIFT cycle with sh_amt=3, done 2 cycles after start, dout=0x08.
REQ-029 SHALL cover: din=0xF0, total_amt=20, dir=1, macro off -> sh_amt sequence 7,7,6, done at cycle 4, dout=0x00; macro on -> single pass sh_amt=4, dout=0x0F.
REQ-030 SHALL cover: din=0x5A, total_amt=0 -> no SHIFT cycle, sh_amt stays 0, done 1 cycle after start, dout=0x5A.
REQ-031 SHALL cover: start re-pulsed with din=0xFF during SHIFT of the REQ-029 operation -> ignored, dout still 0x00, exactly one done pulse.
REQ-032 SHALL cover: reset_n low for 1 cycle during the 2nd SHIFT cycle -> dout=0, busy=0, done=0 immediately; a following start with din=0x01, total_amt=7, dir=0 yields dout=0x80.
REQ-033 SHALL cover: two back-to-back starts (second issued in the IDLE cycle after done) -> two done pulses, each dout correct.
